// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared widths, limits and FSM state encoding for centroid prediction
package motion_pkg;

  localparam logic [10:0] H_MAX_DEF = 11'd1279;
  localparam logic [9:0]  V_MAX_DEF = 10'd719;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int VX_W  = 12;
  localparam int VY_W  = 11;
  localparam int LEAD_W = 4;
  localparam int DX_W  = 16;
  localparam int DY_W  = 15;
  localparam int SUM_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SUM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lead_multiplier.sv
// rtl/lead_multiplier.sv - signed velocity times unsigned 4-bit lead, one lead bit per cycle, LSB first
module lead_multiplier #(
  parameter int VW = 12,
  parameter int PW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic signed [VW-1:0] v,
  input  logic [3:0]           lead,
  output logic signed [PW-1:0] product
);

  logic signed [PW-1:0] mcand;
  logic [3:0]           mplier;

  // The multiplicand may overflow PW bits on late shifts, but the true
  // product always fits, so the wrapped accumulation is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (load) begin
      product <= '0;
      mcand   <= {{(PW-VW){v[VW-1]}}, v};
      mplier  <= lead;
    end else if (step) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand <<< 1;
      mplier <= {1'b0, mplier[3:1]};
    end
  end

endmodule

// File: rtl/com_position_predictor.sv
// rtl/com_position_predictor.sv - predicts a clamped centroid position lead frames ahead from position and velocity
module com_position_predictor
  import motion_pkg::*;
#(
  parameter logic [10:0] H_MAX          = H_MAX_DEF,
  parameter logic [9:0]  V_MAX          = V_MAX_DEF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [X_W-1:0]         x_com_in,
  input  logic [Y_W-1:0]         y_com_in,
  input  logic signed [VX_W-1:0] vx_in,
  input  logic signed [VY_W-1:0] vy_in,
  input  logic [LEAD_W-1:0]      lead_in,
  input  logic                   valid_in,
  output logic [X_W-1:0]         x_pred_out,
  output logic [Y_W-1:0]         y_pred_out,
  output logic [1:0]             clamp_out,
  output logic                   valid_out,
  output logic                   busy_out,
  output logic                   stale_out
);

  localparam logic signed [SUM_W-1:0] H_LIM = {6'b0, H_MAX};
  localparam logic signed [SUM_W-1:0] V_LIM = {7'b0, V_MAX};

  state_t                   state;
  logic [1:0]               mul_cnt;
  logic [X_W-1:0]           x_q;
  logic [Y_W-1:0]           y_q;
  logic signed [SUM_W-1:0]  px;
  logic signed [SUM_W-1:0]  py;
  logic signed [DX_W-1:0]   dx;
  logic signed [DY_W-1:0]   dy;
  logic [15:0]              idle_cnt;
  logic                     accept;
  logic                     mul_step;

  assign accept    = (state == ST_IDLE) && valid_in;
  assign mul_step  = (state == ST_MUL);
  assign stale_out = (idle_cnt == TIMEOUT_CYCLES);

  lead_multiplier #(.VW(VX_W), .PW(DX_W)) u_mul_x (
    .clk     (clk_in),
    .rst     (rst_in),
    .load    (accept),
    .step    (mul_step),
    .v       (vx_in),
    .lead    (lead_in),
    .product (dx)
  );

  lead_multiplier #(.VW(VY_W), .PW(DY_W)) u_mul_y (
    .clk     (clk_in),
    .rst     (rst_in),
    .load    (accept),
    .step    (mul_step),
    .v       (vy_in),
    .lead    (lead_in),
    .product (dy)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      mul_cnt    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      px         <= '0;
      py         <= '0;
      idle_cnt   <= '0;
      x_pred_out <= '0;
      y_pred_out <= '0;
      clamp_out  <= '0;
      valid_out  <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;

      // Acceptance takes priority over saturation of the idle counter.
      if (accept) begin
        idle_cnt <= '0;
      end else if (idle_cnt < TIMEOUT_CYCLES) begin
        idle_cnt <= idle_cnt + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            x_q      <= x_com_in;
            y_q      <= y_com_in;
            mul_cnt  <= '0;
            busy_out <= 1'b1;
            state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          mul_cnt <= mul_cnt + 2'd1;
          if (mul_cnt == 2'd3) begin
            state <= ST_SUM;
          end
        end
        ST_SUM: begin
          px    <= $signed({6'b0, x_q}) + $signed({dx[DX_W-1], dx});
          py    <= $signed({7'b0, y_q}) + $signed({{2{dy[DY_W-1]}}, dy});
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (px[SUM_W-1]) begin
            x_pred_out   <= '0;
            clamp_out[1] <= 1'b1;
          end else if (px > H_LIM) begin
            x_pred_out   <= H_MAX;
            clamp_out[1] <= 1'b1;
          end else begin
            x_pred_out   <= px[X_W-1:0];
            clamp_out[1] <= 1'b0;
          end
          if (py[SUM_W-1]) begin
            y_pred_out   <= '0;
            clamp_out[0] <= 1'b1;
          end else if (py > V_LIM) begin
            y_pred_out   <= V_MAX;
            clamp_out[0] <= 1'b1;
          end else begin
            y_pred_out   <= py[Y_W-1:0];
            clamp_out[0] <= 1'b0;
          end
          valid_out <= 1'b1;
          busy_out  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
